// File: rtl/uart_cfg_if.sv
// Purpose : bus bundle for uart_cfg (config, serial lines, TX/RX FIFO access, status).
// Latency : n/a (wiring only).
// Backpressure: n/a; slave = UART side, master = host/bench side.
interface uart_cfg_if #(
  parameter int DVSR_W = 16
);
  logic [DVSR_W-1:0] dvsr;        // baud-tick period in clk cycles, 0 = no ticks
  logic [1:0]        parity_mode; // 00/11 none, 01 even, 10 odd
  logic              stop2;       // TX sends two stop bits
  logic              rx;          // serial in, idle high
  logic              tx;          // serial out, idle high
  logic              wr_uart;     // push w_data into TX FIFO
  logic [7:0]        w_data;
  logic              rd_uart;     // pop RX FIFO head
  logic [7:0]        r_data;      // RX head data, zero-extended
  logic              r_perr;
  logic              r_ferr;
  logic              tx_full;
  logic              tx_empty;
  logic              rx_full;
  logic              rx_empty;
  logic              rx_overrun;  // sticky drop flag
  logic              clr_err;     // clears rx_overrun

  modport slave (
    input  dvsr, parity_mode, stop2, rx, wr_uart, w_data, rd_uart, clr_err,
    output tx, r_data, r_perr, r_ferr, tx_full, tx_empty, rx_full, rx_empty, rx_overrun
  );

  modport master (
    output dvsr, parity_mode, stop2, rx, wr_uart, w_data, rd_uart, clr_err,
    input  tx, r_data, r_perr, r_ferr, tx_full, tx_empty, rx_full, rx_empty, rx_overrun
  );
endinterface

// File: rtl/uart_cfg.sv
// Purpose : UART with runtime baud divisor, parity and stop config, 16x oversampled RX,
//           FWFT TX/RX FIFOs. Ports: clk, reset (sync, active high), bus (uart_cfg_if.slave).
// Latency : RX word visible one cycle after mid-stop sample; tx registered, start bit begins
//           the cycle after the TX FIFO goes non-empty.
// Backpressure: writes to a full TX FIFO are ignored; RX words arriving to a full FIFO are
//           dropped and flagged in the sticky rx_overrun.

// Generic first-word-fall-through FIFO; head is forced to zero while empty.
module uart_cfg_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdat,
  input  logic         i_rd,
  output logic [W-1:0] o_rdat,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0]  r_mem [0:(1<<AW)-1];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_we;
  logic          w_re;

  assign o_empty = (r_cnt == '0);
  assign o_full  = r_cnt[AW];
  // A write when full is accepted only if a read frees the slot in the same cycle.
  assign w_we    = i_wr && (!o_full || i_rd);
  assign w_re    = i_rd && !o_empty;
  assign o_rdat  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wptr] <= i_wdat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_we) r_wptr <= r_wptr + AW'(1);
      if (w_re) r_rptr <= r_rptr + AW'(1);
      if (w_we && !w_re)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_we && w_re) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end
endmodule

module uart_cfg #(
  parameter int DBIT   = 8,
  parameter int FIFO_W = 4,
  parameter int DVSR_W = 16
) (
  input logic      clk,
  input logic      reset,
  uart_cfg_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- baud tick ----------------
  logic [DVSR_W-1:0] r_baud_cnt;
  logic [DVSR_W-1:0] w_dvsr_m1;
  logic              w_tick;

  assign w_dvsr_m1 = bus.dvsr - DVSR_W'(1);
  assign w_tick    = (bus.dvsr != '0) && (r_baud_cnt == w_dvsr_m1);

  // Comparing against the live divisor makes a change apply at the next wrap, or at once
  // when the count is already past the new terminal value.
  always_ff @(posedge clk) begin
    if (reset || bus.dvsr == '0)       r_baud_cnt <= '0;
    else if (r_baud_cnt >= w_dvsr_m1)  r_baud_cnt <= '0;
    else                               r_baud_cnt <= r_baud_cnt + DVSR_W'(1);
  end

  // ---------------- receiver ----------------
  logic [1:0]      r_rx_sync;
  logic            w_rx_in;
  state_t          r_rx_state, w_rx_state;
  logic [3:0]      r_rx_s, w_rx_s;
  logic [2:0]      r_rx_n, w_rx_n;
  logic [DBIT-1:0] r_rx_b, w_rx_b;
  logic [1:0]      r_rx_pm, w_rx_pm;
  logic            r_rx_perr, w_rx_perr;
  logic            w_rx_ferr;
  logic            w_rx_push;
  logic [DBIT+1:0] w_rx_head;
  logic            w_rx_full;
  logic            r_overrun;

  always_ff @(posedge clk) begin
    if (reset) r_rx_sync <= 2'b11;
    else       r_rx_sync <= {r_rx_sync[0], bus.rx};
  end
  assign w_rx_in = r_rx_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= S_IDLE;
      r_rx_s     <= '0;
      r_rx_n     <= '0;
      r_rx_b     <= '0;
      r_rx_pm    <= '0;
      r_rx_perr  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state;
      r_rx_s     <= w_rx_s;
      r_rx_n     <= w_rx_n;
      r_rx_b     <= w_rx_b;
      r_rx_pm    <= w_rx_pm;
      r_rx_perr  <= w_rx_perr;
    end
  end

  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_s     = r_rx_s;
    w_rx_n     = r_rx_n;
    w_rx_b     = r_rx_b;
    w_rx_pm    = r_rx_pm;
    w_rx_perr  = r_rx_perr;
    w_rx_ferr  = 1'b0;
    w_rx_push  = 1'b0;
    case (r_rx_state)
      S_IDLE: if (!w_rx_in) begin
        w_rx_state = S_START;
        w_rx_s     = '0;
        w_rx_pm    = bus.parity_mode;
        w_rx_perr  = 1'b0;
      end
      S_START: if (w_tick) begin
        if (r_rx_s == 4'd7) begin
          // Line must still be low at mid start bit, otherwise treat it as a glitch.
          w_rx_state = w_rx_in ? S_IDLE : S_DATA;
          w_rx_s     = '0;
          w_rx_n     = '0;
        end else w_rx_s = r_rx_s + 4'd1;
      end
      S_DATA: if (w_tick) begin
        if (r_rx_s == 4'd15) begin
          w_rx_s = '0;
          w_rx_b = {w_rx_in, r_rx_b[DBIT-1:1]};
          if (r_rx_n == 3'(DBIT-1)) w_rx_state = (^r_rx_pm) ? S_PARITY : S_STOP;
          else                      w_rx_n     = r_rx_n + 3'd1;
        end else w_rx_s = r_rx_s + 4'd1;
      end
      S_PARITY: if (w_tick) begin
        if (r_rx_s == 4'd15) begin
          // Expected bit is XOR of data for even, inverted for odd (parity_mode[1]).
          w_rx_perr  = w_rx_in ^ (^r_rx_b) ^ r_rx_pm[1];
          w_rx_s     = '0;
          w_rx_state = S_STOP;
        end else w_rx_s = r_rx_s + 4'd1;
      end
      S_STOP: if (w_tick) begin
        if (r_rx_s == 4'd15) begin
          w_rx_ferr  = !w_rx_in;
          w_rx_push  = 1'b1;
          w_rx_state = S_IDLE;
        end else w_rx_s = r_rx_s + 4'd1;
      end
      default: w_rx_state = S_IDLE;
    endcase
  end

  uart_cfg_fifo #(.W(DBIT+2), .AW(FIFO_W)) u_rx_fifo (
    .clk(clk), .reset(reset),
    .i_wr(w_rx_push), .i_wdat({w_rx_ferr, r_rx_perr, r_rx_b}),
    .i_rd(bus.rd_uart), .o_rdat(w_rx_head),
    .o_full(w_rx_full), .o_empty(bus.rx_empty)
  );

  assign bus.rx_full = w_rx_full;
  assign bus.r_data  = 8'(w_rx_head[DBIT-1:0]);
  assign bus.r_perr  = w_rx_head[DBIT];
  assign bus.r_ferr  = w_rx_head[DBIT+1];

  // A push is lost only when full and no read frees a slot in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)                                        r_overrun <= 1'b0;
    else if (w_rx_push && w_rx_full && !bus.rd_uart)  r_overrun <= 1'b1;
    else if (bus.clr_err)                             r_overrun <= 1'b0;
  end
  assign bus.rx_overrun = r_overrun;

  // ---------------- transmitter ----------------
  state_t     r_tx_state, w_tx_state;
  logic [4:0] r_tx_s, w_tx_s;
  logic [2:0] r_tx_n, w_tx_n;
  logic [7:0] r_tx_b, w_tx_b;
  logic       r_tx_pen, w_tx_pen;
  logic       r_tx_par, w_tx_par;
  logic       r_tx_stop2, w_tx_stop2;
  logic       r_tx, w_tx;
  logic       w_tx_pop;
  logic [7:0] w_tx_head;
  logic       w_tx_empty;

  uart_cfg_fifo #(.W(8), .AW(FIFO_W)) u_tx_fifo (
    .clk(clk), .reset(reset),
    .i_wr(bus.wr_uart), .i_wdat(bus.w_data),
    .i_rd(w_tx_pop), .o_rdat(w_tx_head),
    .o_full(bus.tx_full), .o_empty(w_tx_empty)
  );
  assign bus.tx_empty = w_tx_empty;
  assign bus.tx       = r_tx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= S_IDLE;
      r_tx_s     <= '0;
      r_tx_n     <= '0;
      r_tx_b     <= '0;
      r_tx_pen   <= 1'b0;
      r_tx_par   <= 1'b0;
      r_tx_stop2 <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_s     <= w_tx_s;
      r_tx_n     <= w_tx_n;
      r_tx_b     <= w_tx_b;
      r_tx_pen   <= w_tx_pen;
      r_tx_par   <= w_tx_par;
      r_tx_stop2 <= w_tx_stop2;
      r_tx       <= w_tx;
    end
  end

  // w_tx is the line level for the state being entered, so tx changes exactly at bit edges.
  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_s     = r_tx_s;
    w_tx_n     = r_tx_n;
    w_tx_b     = r_tx_b;
    w_tx_pen   = r_tx_pen;
    w_tx_par   = r_tx_par;
    w_tx_stop2 = r_tx_stop2;
    w_tx       = r_tx;
    w_tx_pop   = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        w_tx = 1'b1;
        if (!w_tx_empty) begin
          w_tx_state = S_START;
          w_tx_s     = '0;
          w_tx_n     = '0;
          w_tx_b     = w_tx_head;
          w_tx_pen   = ^bus.parity_mode;
          w_tx_par   = (^w_tx_head[DBIT-1:0]) ^ bus.parity_mode[1];
          w_tx_stop2 = bus.stop2;
          w_tx       = 1'b0;
        end
      end
      S_START: if (w_tick) begin
        if (r_tx_s == 5'd15) begin
          w_tx_state = S_DATA;
          w_tx_s     = '0;
          w_tx       = r_tx_b[0];
        end else w_tx_s = r_tx_s + 5'd1;
      end
      S_DATA: if (w_tick) begin
        if (r_tx_s == 5'd15) begin
          w_tx_s = '0;
          w_tx_b = r_tx_b >> 1;
          if (r_tx_n == 3'(DBIT-1)) begin
            w_tx_state = r_tx_pen ? S_PARITY : S_STOP;
            w_tx       = r_tx_pen ? r_tx_par : 1'b1;
          end else begin
            w_tx_n = r_tx_n + 3'd1;
            w_tx   = r_tx_b[1];
          end
        end else w_tx_s = r_tx_s + 5'd1;
      end
      S_PARITY: if (w_tick) begin
        if (r_tx_s == 5'd15) begin
          w_tx_state = S_STOP;
          w_tx_s     = '0;
          w_tx       = 1'b1;
        end else w_tx_s = r_tx_s + 5'd1;
      end
      S_STOP: if (w_tick) begin
        if (r_tx_s == (r_tx_stop2 ? 5'd31 : 5'd15)) begin
          w_tx_state = S_IDLE;
          w_tx_pop   = 1'b1;
          w_tx       = 1'b1;
        end else w_tx_s = r_tx_s + 5'd1;
      end
      default: w_tx_state = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_cfg.sv
// Purpose : self-checking bench for uart_cfg: scoreboard of expected RX words popped by a
//           monitor, plus direct checks of tx waveform, FIFO flags, overrun and reset.
// Latency : bit time is 64 clk cycles (dvsr=4).
// Backpressure: monitor reads the RX FIFO whenever it is enabled and non-empty.
module tb_uart_cfg;
  localparam int BIT = 64;

  logic clk = 1'b0;
  logic reset;
  logic tb_rx;
  logic loop;
  always #5 clk = ~clk;

  uart_cfg_if #(.DVSR_W(16)) bus ();
  assign bus.rx = loop ? bus.tx : tb_rx;

  uart_cfg #(.DBIT(8), .FIFO_W(4), .DVSR_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  int         errors = 0;
  int         checks = 0;
  logic [9:0] q[$];
  bit         mon_en  = 1'b0;
  bit         exp_ovr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Parity bit a correct sender would transmit: total ones even (01) or odd (10).
  function automatic logic par_bit(input logic [7:0] d, input logic [1:0] pm);
    int pc = $countones(d);
    return (pm == 2'b10) ? (pc % 2 == 0) : (pc % 2 == 1);
  endfunction

  function automatic logic [9:0] exp_word(input logic [7:0] d, input logic [1:0] pm,
                                          input logic bad, input logic stopb);
    logic pe = (pm == 2'b01 || pm == 2'b10) ? bad : 1'b0;
    return {!stopb, pe, d};
  endfunction

  task automatic expect_word(input logic [9:0] w);
    if (q.size() >= 16) exp_ovr = 1'b1;
    else q.push_back(w);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame on rx; the expected word is queued before the DUT can push it.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm,
                            input logic bad, input logic stopb);
    expect_word(exp_word(d, pm, bad, stopb));
    tb_rx = 1'b0; wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin tb_rx = d[i]; wait_cyc(BIT); end
    if (pm == 2'b01 || pm == 2'b10) begin tb_rx = par_bit(d, pm) ^ bad; wait_cyc(BIT); end
    tb_rx = stopb;
    // A low stop bit is released early so the return to idle is not mistaken for a start.
    if (stopb) wait_cyc(BIT); else wait_cyc(44);
    tb_rx = 1'b1; wait_cyc(2 * BIT);
  endtask

  task automatic write_tx(input logic [7:0] d);
    bus.wr_uart = 1'b1; bus.w_data = d; @(negedge clk);
    bus.wr_uart = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    while ((q.size() != 0 || !bus.rx_empty) && t < 6000) begin @(negedge clk); t++; end
    chk({nm, "_left"}, q.size(), 0);
    chk({nm, "_rx_empty"}, bus.rx_empty, 1);
  endtask

  task automatic wait_tx_fall(output bit ok);
    int t = 0;
    while (bus.tx !== 1'b0 && t < 400) begin @(negedge clk); t++; end
    ok = (bus.tx === 1'b0);
  endtask

  // Monitor: pops and compares the RX head whenever enabled and the FIFO is non-empty.
  initial begin
    bus.rd_uart = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && bus.rx_empty === 1'b0) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_word: got unexpected word %0h, expected none",
                   {bus.r_ferr, bus.r_perr, bus.r_data});
        end else begin
          chk("rx_word", {bus.r_ferr, bus.r_perr, bus.r_data}, q.pop_front());
        end
        bus.rd_uart = 1'b1;
        @(negedge clk);
        bus.rd_uart = 1'b0;
      end
    end
  end

  initial begin
    bit         ok;
    logic [7:0] d;
    logic [1:0] pm;
    logic       bad, stopb;
    logic       expb [11];
    int         lows;

    reset = 1'b1; tb_rx = 1'b1; loop = 1'b0;
    bus.dvsr = 16'd4; bus.parity_mode = 2'b00; bus.stop2 = 1'b0;
    bus.wr_uart = 1'b0; bus.w_data = 8'h00; bus.clr_err = 1'b0;
    wait_cyc(3);
    chk("rst_tx", bus.tx, 1);
    chk("rst_tx_empty", bus.tx_empty, 1);
    chk("rst_rx_empty", bus.rx_empty, 1);
    chk("rst_tx_full", bus.tx_full, 0);
    chk("rst_rx_full", bus.rx_full, 0);
    chk("rst_overrun", bus.rx_overrun, 0);
    chk("rst_r_data", bus.r_data, 0);
    chk("rst_r_perr", bus.r_perr, 0);
    chk("rst_r_ferr", bus.r_ferr, 0);
    reset = 1'b0;
    wait_cyc(2);

    // TX FIFO capacity with ticks disabled: 16 words fill it, the 17th is ignored.
    bus.dvsr = 16'd0;
    for (int i = 0; i < 16; i++) write_tx(8'(i));
    chk("tx_full_16", bus.tx_full, 1);
    write_tx(8'hEE);
    chk("tx_full_17", bus.tx_full, 1);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("tx_rst_empty", bus.tx_empty, 1);
    chk("tx_rst_line", bus.tx, 1);
    bus.dvsr = 16'd4;
    wait_cyc(4);

    // Waveform of 0xA5, even parity, one stop bit.
    d = 8'hA5; bus.parity_mode = 2'b01; bus.stop2 = 1'b0;
    expb[0] = 1'b0;
    for (int i = 0; i < 8; i++) expb[1+i] = d[i];
    expb[9] = par_bit(d, 2'b01);
    expb[10] = 1'b1;
    write_tx(d);
    wait_tx_fall(ok);
    chk("tx_start_seen", ok, 1);
    wait_cyc(BIT / 2);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("tx_bit%0d", k), bus.tx, expb[k]);
      wait_cyc(BIT);
    end
    chk("tx_empty_after", bus.tx_empty, 1);

    // Randomized RX frames through the scoreboard.
    mon_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      d     = 8'($urandom_range(0, 255));
      pm    = 2'($urandom_range(0, 3));
      bad   = (pm == 2'b01 || pm == 2'b10) ? 1'($urandom_range(0, 1)) : 1'b0;
      stopb = ($urandom_range(0, 3) != 0);
      bus.parity_mode = pm;
      send_frame(d, pm, bad, stopb);
    end
    // 0x55 with wrong parity bit and a low stop bit.
    bus.parity_mode = 2'b01;
    send_frame(8'h55, 2'b01, 1'b1, 1'b0);
    wait_drain("rx_rand");

    // Start-bit glitch of 5 ticks must be rejected, then a clean frame.
    tb_rx = 1'b0; wait_cyc(20); tb_rx = 1'b1; wait_cyc(4 * BIT);
    chk("glitch_no_push", bus.rx_empty, 1);
    bus.parity_mode = 2'b00;
    send_frame(8'hC3, 2'b00, 1'b0, 1'b1);
    wait_drain("glitch");

    // Loopback, odd parity, two stop bits.
    bus.parity_mode = 2'b10; bus.stop2 = 1'b1; loop = 1'b1;
    wait_cyc(4);
    expect_word(exp_word(8'h00, 2'b10, 1'b0, 1'b1)); write_tx(8'h00);
    expect_word(exp_word(8'hFF, 2'b10, 1'b0, 1'b1)); write_tx(8'hFF);
    expect_word(exp_word(8'h3C, 2'b10, 1'b0, 1'b1)); write_tx(8'h3C);
    wait_drain("loop");
    loop = 1'b0; bus.stop2 = 1'b0;
    wait_cyc(8);

    // 17 frames without reads: 16 kept, the 17th dropped and flagged.
    mon_en = 1'b0; bus.parity_mode = 2'b00; exp_ovr = 1'b0;
    wait_cyc(4);
    for (int f = 0; f < 17; f++) begin
      send_frame(8'($urandom_range(0, 255)), 2'b00, 1'b0, 1'b1);
      if (f == 15) chk("ovr_after16", bus.rx_overrun, 0);
    end
    chk("ovr_rx_full", bus.rx_full, 1);
    chk("ovr_flag", bus.rx_overrun, exp_ovr);
    bus.clr_err = 1'b1; @(negedge clk); bus.clr_err = 1'b0;
    exp_ovr = 1'b0;
    chk("ovr_cleared", bus.rx_overrun, exp_ovr);
    mon_en = 1'b1;
    wait_drain("ovr");

    // Reset at tick 40 of the TX data phase aborts the frame.
    bus.parity_mode = 2'b00;
    write_tx(8'h5A);
    wait_tx_fall(ok);
    chk("abort_start_seen", ok, 1);
    wait_cyc((16 + 40) * 4);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_tx_line", bus.tx, 1);
    chk("abort_tx_empty", bus.tx_empty, 1);
    @(negedge clk); reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 400; i++) begin @(negedge clk); if (bus.tx !== 1'b1) lows++; end
    chk("abort_tx_quiet", lows, 0);
    chk("abort_tx_empty_end", bus.tx_empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
